bus_arbiter_16bit: RTL and testbench



---
 rtl/bus_arb_pkg.sv | 9 +
 rtl/arb_rr_pick.sv | 16 +
 rtl/bus_arbiter_16bit.sv | 121 ++++++++++++
 tb/tb_bus_arbiter_16bit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and default parameters for the 2-way bus arbiter.
//   state_e         : arbiter FSM states (IDLE, OWN0, OWN1)
//   DATA_W_DEF      : default datapath width
//   TIMEOUT_CYC_DEF : default maximum ownership length (timeout build only)
package bus_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
  localparam int DATA_W_DEF = 16;
  localparam int TIMEOUT_CYC_DEF = 15;
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational 2-way round-robin picker.
//   req0, req1 : eligible requests
//   rr_last    : most recently granted requester (loses a tie)
//   pick_valid : at least one request present
//   pick       : chosen requester (0 or 1), meaningful when pick_valid
module arb_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic pick_valid,
  output logic pick
);
  assign pick_valid = req0 | req1;
  // req1 wins unless req0 is also asking and req1 was served last
  assign pick = req1 & ~(req0 & rr_last);
endmodule

// File: rtl/bus_arbiter_16bit.sv
// bus_arbiter_16bit: round-robin burst arbiter sharing one datapath between two requesters.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req0/1, last0/1     : burst request and final-beat flag per requester
//   in0/1               : requester data
//   gnt0/1, sel         : registered grants and mux select
//   out_data, out_valid : combinational shared-bus beat toward the consumer
//   out_ready           : consumer accepts the beat
//   timeout_err         : one-cycle pulse after a forced release
// Define BUS_ARB_TIMEOUT_EN to bound ownership to TIMEOUT_CYC cycles; otherwise
// timeout_err is tied low and a burst may hold the bus indefinitely.
module bus_arbiter_16bit
  import bus_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              last0,
  input  logic              last1,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              timeout_err
);
  state_e state_q, state_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, sel_q, sel_d, rr_last_q, rr_last_d;
  logic r0, r1, tmo, xfer, own_req, own_last, other_req, done, grant, gnt_to;
  logic pick_valid, pick;

  assign out_data  = sel_q ? in1 : in0;
  assign out_valid = (gnt0_q & req0) | (gnt1_q & req1);
  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign sel  = sel_q;
  assign xfer = out_valid & out_ready;

  // while owning, sel identifies the owner
  assign own_req   = sel_q ? req1 : req0;
  assign own_last  = sel_q ? last1 : last0;
  assign other_req = sel_q ? r0 : r1;
  assign done  = (state_q != IDLE) & ((xfer & own_last) | ~own_req | tmo);
  assign grant = (state_q == IDLE) ? pick_valid : done & other_req;
  assign gnt_to = (state_q == IDLE) ? pick : ~sel_q;

  arb_rr_pick u_pick (
    .req0      (r0),
    .req1      (r1),
    .rr_last   (rr_last_q),
    .pick_valid(pick_valid),
    .pick      (pick)
  );

  always_comb begin
    state_d   = grant ? (gnt_to ? OWN1 : OWN0) : done ? IDLE : state_q;
    gnt0_d    = grant ? ~gnt_to : done ? 1'b0 : gnt0_q;
    gnt1_d    = grant ? gnt_to : done ? 1'b0 : gnt1_q;
    sel_d     = grant ? gnt_to : sel_q;
    rr_last_d = grant ? gnt_to : rr_last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      sel_q     <= 1'b0;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      sel_q     <= sel_d;
      rr_last_q <= rr_last_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic blk0_q, blk0_d, blk1_q, blk1_d, terr_q;

  // a timed-out requester stays ineligible until it drops req once
  assign r0  = req0 & ~blk0_q;
  assign r1  = req1 & ~blk1_q;
  assign tmo = (state_q != IDLE) & ~((xfer & own_last) | ~own_req) & (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign timeout_err = terr_q;

  always_comb begin
    cnt_d  = (grant | done) ? '0 : (state_q != IDLE) ? cnt_q + 1'b1 : cnt_q;
    blk0_d = (blk0_q & req0) | (tmo & ~sel_q);
    blk1_d = (blk1_q & req1) | (tmo & sel_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      blk0_q <= 1'b0;
      blk1_q <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      blk0_q <= blk0_d;
      blk1_q <= blk1_d;
      terr_q <= tmo;
    end
  end
`else
  assign r0  = req0;
  assign r1  = req1;
  assign tmo = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_bus_arbiter_16bit.sv
// tb_bus_arbiter_16bit: randomized scoreboard bench for bus_arbiter_16bit.
module tb_bus_arbiter_16bit;
  localparam int TO = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TOEN = 1'b1;
`else
  localparam bit TOEN = 1'b0;
`endif

  typedef struct packed {
    logic g0, g1, s, te, v;
    logic [15:0] d;
  } st_t;

  logic clk = 1'b0, rst_n = 1'b1;
  logic req0 = 0, req1 = 0, last0 = 0, last1 = 0, out_ready = 0;
  logic [15:0] in0 = 0, in1 = 0;
  logic gnt0, gnt1, sel, out_valid, timeout_err;
  logic [15:0] out_data;

  int checks = 0, failures = 0;
  st_t st_q[$];
  logic [15:0] beat_q[$];

  bit m_own_v, m_own, m_rr, m_sel, m_terr, m_xfer;
  bit m_blk[2];
  int m_cnt, xsrc;
  int rem[2];

  bus_arbiter_16bit #(.DATA_W(16), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .last0(last0), .last1(last1),
    .in0(in0), .in1(in1), .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_own_v = 0; m_own = 0; m_rr = 1; m_sel = 0; m_terr = 0; m_cnt = 0;
    m_blk[0] = 0; m_blk[1] = 0;
  endfunction

  // expected outputs for the current cycle, from model state and current inputs
  function automatic void push_exp();
    st_t e;
    logic v;
    v = m_own_v && (m_own ? req1 : req0);
    m_xfer = v && out_ready;
    xsrc = m_xfer ? int'(m_own) : -1;
    e.g0 = m_own_v && !m_own;
    e.g1 = m_own_v && m_own;
    e.s  = m_sel;
    e.te = m_terr;
    e.v  = v;
    e.d  = m_sel ? in1 : in0;
    st_q.push_back(e);
    if (m_xfer) beat_q.push_back(m_own ? in1 : in0);
  endfunction

  // ownership rules applied at the clock edge
  function automatic void model_update();
    bit q[2], l[2], e[2];
    bit fin, to;
    int g;
    q[0] = req0; q[1] = req1; l[0] = last0; l[1] = last1;
    to = 0; g = -1;
    for (int i = 0; i < 2; i++) e[i] = q[i] && !m_blk[i];
    if (!m_own_v) begin
      if (e[0] && e[1]) g = m_rr ? 0 : 1;
      else if (e[0]) g = 0;
      else if (e[1]) g = 1;
    end else begin
      fin = (m_xfer && l[m_own]) || !q[m_own];
      to = TOEN && !fin && (m_cnt == TO - 1);
      m_cnt++;
      if (fin || to) begin
        if (e[!m_own]) g = m_own ? 0 : 1;
        else m_own_v = 0;
      end
    end
    for (int i = 0; i < 2; i++) m_blk[i] = (m_blk[i] && q[i]) || (to && int'(m_own) == i);
    m_terr = to;
    if (g >= 0) begin
      m_own_v = 1; m_own = g[0]; m_rr = g[0]; m_sel = g[0]; m_cnt = 0;
    end
  endfunction

  task automatic drive(input logic q0, q1, l0, l1, rdy, input logic [15:0] d0, d1);
    req0 = q0; req1 = q1; last0 = l0; last1 = l1; out_ready = rdy; in0 = d0; in1 = d1;
    push_exp();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    st_t e;
    rst_n = 1'b0;
    model_reset();
    e = '{g0: 0, g1: 0, s: 0, te: 0, v: 0, d: in0};
    st_q.push_back(e);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    st_t e;
    logic [15:0] d;
    if (st_q.size() != 0) begin
      e = st_q.pop_front();
      checks++;
      if ({gnt0, gnt1, sel, timeout_err, out_valid, out_data} !== e) begin
        failures++;
        $display("FAIL state t=%0t got g0=%b g1=%b sel=%b terr=%b vld=%b data=%h exp g0=%b g1=%b sel=%b terr=%b vld=%b data=%h",
                 $time, gnt0, gnt1, sel, timeout_err, out_valid, out_data, e.g0, e.g1, e.s, e.te, e.v, e.d);
      end
    end
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (beat_q.size() == 0) begin
        failures++;
        $display("FAIL beat t=%0t got unexpected beat %h exp none", $time, out_data);
      end else begin
        d = beat_q.pop_front();
        if (out_data !== d) begin
          failures++;
          $display("FAIL beat t=%0t got %h exp %h", $time, out_data, d);
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    // tie after reset: req0 first, then zero-bubble handoff to req1
    drive(1, 1, 1, 0, 1, 16'hAAAA, 16'h5555);
    drive(1, 1, 1, 0, 1, 16'hAAAA, 16'h5555);
    drive(0, 1, 0, 1, 1, 16'hAAAA, 16'h5555);
    drive(0, 0, 0, 0, 1, 16'hAAAA, 16'h5555);
    // req1 alone, 4-beat burst, then IDLE with sel held at 1
    drive(0, 1, 0, 0, 1, 16'h0, 16'h0000);
    for (int i = 1; i <= 4; i++) drive(0, 1, 0, i == 4, 1, 16'h0, 16'(i));
    drive(0, 0, 0, 0, 1, 16'h1234, 16'h4321);
    drive(0, 0, 0, 0, 1, 16'h1234, 16'h4321);
    // owner stalled 3 cycles while the other side waits
    drive(1, 1, 0, 0, 1, 16'hBEEF, 16'h0F0F);
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 0, 16'hBEEF, 16'h0F0F);
    drive(1, 1, 1, 0, 1, 16'hBEEF, 16'h0F0F);
    drive(0, 1, 0, 1, 1, 16'hBEEF, 16'h0F0F);
    drive(0, 0, 0, 0, 1, 16'h0, 16'h0);
    // reset in the middle of an OWN1 burst, then a tie must go to req0
    drive(0, 1, 0, 0, 1, 16'h1111, 16'h2222);
    drive(0, 1, 0, 0, 1, 16'h1111, 16'h2222);
    do_reset();
    drive(1, 1, 0, 0, 0, 16'h3333, 16'h4444);
    drive(1, 1, 1, 0, 1, 16'h3333, 16'h4444);
    drive(0, 1, 0, 1, 1, 16'h3333, 16'h4444);
    drive(0, 0, 0, 0, 1, 16'h0, 16'h0);
    // req0 abandons its burst while req1 waits
    drive(1, 0, 0, 0, 1, 16'h5A5A, 16'hA5A5);
    drive(1, 1, 0, 0, 1, 16'h5A5A, 16'hA5A5);
    drive(0, 1, 0, 0, 1, 16'h5A5A, 16'hA5A5);
    drive(0, 1, 0, 1, 1, 16'h5A5A, 16'hA5A5);
    drive(0, 0, 0, 0, 1, 16'h0, 16'h0);
    // req0 holds without last while req1 waits (forced handoff in timeout build)
    drive(1, 0, 0, 0, 1, 16'h7777, 16'h8888);
    for (int i = 0; i < 6; i++) drive(1, 1, 0, 0, 1, 16'(16'h7000 + i), 16'h8888);
    drive(1, 1, 0, 1, 1, 16'h7777, 16'h8888);
    drive(0, 0, 0, 0, 1, 16'h0, 16'h0);
    drive(0, 0, 0, 0, 1, 16'h0, 16'h0);
    // randomized bursts, stalls, abandons and one reset
    rem[0] = 0; rem[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 2) == 0) rem[i] = $urandom_range(1, 6);
        else if (rem[i] > 0 && $urandom_range(0, 29) == 0) rem[i] = 0;
      end
      drive(rem[0] > 0, rem[1] > 0,
            rem[0] == 1 || (rem[0] == 0 && $urandom_range(0, 1) == 1),
            rem[1] == 1 || (rem[1] == 0 && $urandom_range(0, 1) == 1),
            $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom));
      if (xsrc >= 0) rem[xsrc]--;
      if (c == 1500) begin
        do_reset();
        rem[0] = 0; rem[1] = 0;
      end
    end
    drive(0, 0, 0, 0, 1, 16'h0, 16'h0);
    @(negedge clk);
    #1;
    checks++;
    if (beat_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d beats outstanding exp 0", beat_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
